// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - note-to-voice allocator driving per-voice envelope gates and a shared update tick
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_BITS  = 7,
    parameter int AGE_BITS   = 8,
    parameter int TICK_DIV   = 2048
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            evt_valid,
    output logic                            evt_ready,
    input  logic                            evt_note_on,
    input  logic [NOTE_BITS-1:0]            evt_note,
    input  logic [NUM_VOICES-1:0]           voice_avail,
    output logic [NUM_VOICES-1:0]           voice_gate,
    output logic                            voice_tick,
    output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note,
    output logic [NUM_VOICES-1:0]           voice_busy
);
    localparam int IDX_BITS = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CNT_BITS = $clog2(TICK_DIV);
    localparam logic [AGE_BITS-1:0] AGE_MAX = {AGE_BITS{1'b1}};

    typedef enum logic [1:0] {ACCEPT, SEARCH, COMMIT} ctrl_t;
    typedef enum logic [1:0] {IDLE, HELD, RELEASE} vstate_t;
    typedef enum logic [1:0] {ACT_NONE, ACT_ON, ACT_OFF} act_t;

    ctrl_t                 state, state_next;
    act_t                  act, act_next;
    logic [IDX_BITS-1:0]   tgt, tgt_next;
    logic                  ev_on;
    logic [NOTE_BITS-1:0]  ev_note;
    vstate_t               vstate [NUM_VOICES];
    logic [NOTE_BITS-1:0]  vnote  [NUM_VOICES];
    logic [AGE_BITS-1:0]   vage   [NUM_VOICES];
    logic [CNT_BITS-1:0]   cnt;

    logic                  hit_found, idle_found, rel_found, held_found, off_found;
    logic [IDX_BITS-1:0]   hit_idx, idle_idx, rel_idx, held_idx, off_idx;
    logic [AGE_BITS-1:0]   rel_age, held_age;

    assign evt_ready = (state == ACCEPT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACCEPT;
            ev_on   <= 1'b0;
            ev_note <= '0;
            tgt     <= '0;
            act     <= ACT_NONE;
        end else begin
            state <= state_next;
            if (evt_valid && evt_ready) begin
                ev_on   <= evt_note_on;
                ev_note <= evt_note;
            end
            if (state == SEARCH) begin
                tgt <= tgt_next;
                act <= act_next;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCEPT:  if (evt_valid) state_next = SEARCH;
            SEARCH:  state_next = COMMIT;
            COMMIT:  state_next = ACCEPT;
            default: state_next = ACCEPT;
        endcase
    end

    // Strict '>' on age keeps the lowest index on ties.
    always_comb begin
        hit_found  = 1'b0; hit_idx  = '0;
        idle_found = 1'b0; idle_idx = '0;
        rel_found  = 1'b0; rel_idx  = '0; rel_age  = '0;
        held_found = 1'b0; held_idx = '0; held_age = '0;
        off_found  = 1'b0; off_idx  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (vstate[i] != IDLE && vnote[i] == ev_note && !hit_found) begin
                hit_found = 1'b1;
                hit_idx   = IDX_BITS'(i);
            end
            if (vstate[i] == IDLE && !idle_found) begin
                idle_found = 1'b1;
                idle_idx   = IDX_BITS'(i);
            end
            if (vstate[i] == RELEASE && (!rel_found || vage[i] > rel_age)) begin
                rel_found = 1'b1;
                rel_idx   = IDX_BITS'(i);
                rel_age   = vage[i];
            end
            if (vstate[i] == HELD && (!held_found || vage[i] > held_age)) begin
                held_found = 1'b1;
                held_idx   = IDX_BITS'(i);
                held_age   = vage[i];
            end
            if (vstate[i] == HELD && vnote[i] == ev_note && !off_found) begin
                off_found = 1'b1;
                off_idx   = IDX_BITS'(i);
            end
        end
        act_next = ACT_NONE;
        tgt_next = '0;
        if (ev_on) begin
            act_next = ACT_ON;
            if (hit_found)       tgt_next = hit_idx;
            else if (idle_found) tgt_next = idle_idx;
            else if (rel_found)  tgt_next = rel_idx;
            else                 tgt_next = held_idx;
        end else if (off_found) begin
            act_next = ACT_OFF;
            tgt_next = off_idx;
        end
    end

    // Later assignments override: a commit to voice i beats its avail pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                vstate[i] <= IDLE;
                vnote[i]  <= '0;
                vage[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (voice_avail[i] && vstate[i] == RELEASE) begin
                    vstate[i] <= IDLE;
                    vage[i]   <= '0;
                end
                if (state == COMMIT && act == ACT_ON) begin
                    if (tgt == IDX_BITS'(i)) begin
                        vstate[i] <= HELD;
                        vnote[i]  <= ev_note;
                        vage[i]   <= '0;
                    end else if (vstate[i] != IDLE && !(voice_avail[i] && vstate[i] == RELEASE)
                                 && vage[i] != AGE_MAX) begin
                        vage[i] <= vage[i] + AGE_BITS'(1);
                    end
                end
                if (state == COMMIT && act == ACT_OFF && tgt == IDX_BITS'(i)) begin
                    vstate[i] <= RELEASE;
                end
            end
        end
    end

    // Tick is registered one count early so it is high while cnt == TICK_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            voice_tick <= 1'b0;
        end else begin
            cnt        <= (cnt == CNT_BITS'(TICK_DIV - 1)) ? '0 : cnt + CNT_BITS'(1);
            voice_tick <= (cnt == CNT_BITS'(TICK_DIV - 2));
        end
    end

    always_comb begin
        voice_gate = '0;
        voice_busy = '0;
        voice_note = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_gate[i] = (vstate[i] == HELD);
            voice_busy[i] = (vstate[i] != IDLE);
            voice_note[i*NOTE_BITS +: NOTE_BITS] = vnote[i];
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - directed self-checking bench for voice_allocator
module tb_voice_allocator;
    localparam int NV = 4;
    localparam int NB = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          evt_valid = 1'b0;
    logic          evt_note_on = 1'b0;
    logic [NB-1:0] evt_note = '0;
    logic [NV-1:0] voice_avail = '0;
    logic          evt_ready, voice_tick;
    logic [NV-1:0] voice_gate, voice_busy;
    logic [NV*NB-1:0] voice_note;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    voice_allocator #(.NUM_VOICES(NV), .NOTE_BITS(NB), .AGE_BITS(8), .TICK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_note_on(evt_note_on), .evt_note(evt_note), .voice_avail(voice_avail),
        .voice_gate(voice_gate), .voice_tick(voice_tick), .voice_note(voice_note),
        .voice_busy(voice_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic on, input logic [NB-1:0] note,
                        output logic [NV-1:0] gate_search, output logic [NV-1:0] gate_commit);
        int n = 0;
        @(negedge clk);
        while (!evt_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", evt_ready, 1);
        evt_valid = 1'b1; evt_note_on = on; evt_note = note;
        @(posedge clk); #1;
        evt_valid = 1'b0; evt_note_on = ~on; evt_note = ~note;
        chk("ready_search", evt_ready, 0);
        gate_search = voice_gate;
        @(posedge clk); #1;
        chk("ready_commit", evt_ready, 0);
        gate_commit = voice_gate;
        @(posedge clk); #1;
        chk("ready_back", evt_ready, 1);
    endtask

    task automatic pulse_avail(input logic [NV-1:0] mask);
        @(negedge clk);
        voice_avail = mask;
        @(posedge clk); #1;
        voice_avail = '0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NV-1:0] gs, gc;
        int pulses, last, bad_gap, bad_idle;
        pulses = 0; last = -1; bad_gap = 0; bad_idle = 0;

        // Reset and idle ticking
        @(negedge clk); @(negedge clk);
        chk("rst_gate", voice_gate, 0);
        chk("rst_busy", voice_busy, 0);
        chk("rst_note", voice_note, 0);
        chk("rst_tick", voice_tick, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (!evt_ready || voice_gate != 0 || voice_busy != 0 || voice_note != 0) bad_idle++;
            if (voice_tick) begin
                if (last >= 0 && c - last != 4) bad_gap++;
                last = c;
                pulses++;
            end
        end
        chk("idle_outputs", bad_idle, 0);
        chk("tick_count", pulses, 5);
        chk("tick_spacing", bad_gap, 0);

        // Free-voice allocation and gate latency
        send(1'b1, 7'd60, gs, gc);
        chk("on60_gate_search", gs, 4'b0000);
        chk("on60_gate_commit", gc, 4'b0000);
        chk("on60_gate", voice_gate, 4'b0001);
        send(1'b1, 7'd62, gs, gc);
        chk("on62_gate_commit", gc, 4'b0001);
        chk("on62_gate", voice_gate, 4'b0011);
        send(1'b1, 7'd64, gs, gc);
        chk("on64_gate_commit", gc, 4'b0011);
        chk("on64_gate", voice_gate, 4'b0111);
        chk("three_notes", voice_note, {7'd0, 7'd64, 7'd62, 7'd60});

        // Release, avail return, reuse of freed voice
        send(1'b0, 7'd62, gs, gc);
        chk("off62_gate", voice_gate, 4'b0101);
        chk("off62_busy", voice_busy, 4'b0111);
        pulse_avail(4'b0010);
        chk("avail1_busy", voice_busy, 4'b0101);
        send(1'b1, 7'd67, gs, gc);
        chk("on67_gate", voice_gate, 4'b0111);
        chk("on67_notes", voice_note, {7'd0, 7'd64, 7'd67, 7'd60});

        // Stealing: RELEASE preferred, then oldest HELD
        do_reset();
        send(1'b1, 7'd60, gs, gc);
        send(1'b1, 7'd62, gs, gc);
        send(1'b1, 7'd64, gs, gc);
        send(1'b1, 7'd65, gs, gc);
        chk("fill_gate", voice_gate, 4'b1111);
        send(1'b0, 7'd62, gs, gc);
        chk("fill_off62_gate", voice_gate, 4'b1101);
        send(1'b1, 7'd70, gs, gc);
        chk("steal_rel_gate", voice_gate, 4'b1111);
        chk("steal_rel_notes", voice_note, {7'd65, 7'd64, 7'd70, 7'd60});
        send(1'b1, 7'd72, gs, gc);
        chk("steal_old_notes", voice_note, {7'd65, 7'd64, 7'd70, 7'd72});

        // Retrigger resets age; unmatched off is a no-op; avail ignored when HELD
        do_reset();
        send(1'b1, 7'd60, gs, gc);
        send(1'b1, 7'd62, gs, gc);
        send(1'b1, 7'd60, gs, gc);
        chk("retrig_busy", voice_busy, 4'b0011);
        chk("retrig_notes", voice_note, {7'd0, 7'd0, 7'd62, 7'd60});
        send(1'b0, 7'd60, gs, gc);
        chk("retrig_off_gate", voice_gate, 4'b0010);
        send(1'b1, 7'd60, gs, gc);
        chk("retrig_rel_gate", voice_gate, 4'b0011);
        chk("retrig_rel_busy", voice_busy, 4'b0011);
        send(1'b1, 7'd64, gs, gc);
        send(1'b1, 7'd65, gs, gc);
        send(1'b1, 7'd80, gs, gc);
        chk("age_steal_notes", voice_note, {7'd65, 7'd64, 7'd80, 7'd60});
        send(1'b0, 7'd99, gs, gc);
        chk("off99_gate", voice_gate, 4'b1111);
        chk("off99_notes", voice_note, {7'd65, 7'd64, 7'd80, 7'd60});
        pulse_avail(4'b1111);
        chk("avail_held_busy", voice_busy, 4'b1111);

        // Asynchronous reset during COMMIT
        @(negedge clk);
        evt_valid = 1'b1; evt_note_on = 1'b1; evt_note = 7'd33;
        @(posedge clk); #1;
        evt_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gate", voice_gate, 0);
        chk("arst_busy", voice_busy, 0);
        chk("arst_note", voice_note, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_ready", evt_ready, 1);
        send(1'b1, 7'd50, gs, gc);
        chk("arst_realloc_gate", voice_gate, 4'b0001);
        chk("arst_realloc_note", voice_note, {7'd0, 7'd0, 7'd0, 7'd50});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
